alu_pipe: RTL
=============

# alu_pipe

Parametrised, handshaked successor to the CPU's single-cycle ALU: executes logic, arithmetic, shift and compare operations in one cycle and multiplication iteratively over several cycles. It sits in the EX stage behind a valid/ready interface, so the pipeline stalls only while a multiply is in flight. It keeps the existing 4-bit control codes, adds new operations and flags, and registers every result.

## Interface
- WIDTH, 32, operand/result width; power of two, ≥ 8
- MUL_BPC, 1, multiplier bits retired per iteration; must divide WIDTH (1, 2, 4, 8)
- clk_i  input  1  clock; all state updates on rising edge
- rst_i  input  1  reset; synchronous, active-high
- in_valid_i  input  1  operation presented
- in_ready_o  output  1  block accepts operation this cycle
- src1_i  input  WIDTH  operand A
- src2_i  input  WIDTH  operand B
- ctrl_i  input  4  operation code
- out_valid_o  output  1  result registers hold a valid result
- out_ready_i  input  1  consumer takes result this cycle
- result_o  output  WIDTH  result
- zero_o  output  1  result_o == 0
- ovf_o  output  1  signed overflow (ADD/SUB only, else 0)
- illegal_o  output  1  ctrl code undefined (result 0)

## Operation
- Codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0011 MUL (low WIDTH bits of product), 0100 XOR, 0101 SLL, 1000 SRL, 1001 SRA, 0111 SLT (signed, result 1/0), 1010 SLTU. All other codes: result 0, illegal_o=1, single-cycle.
- Shift amount = src2_i[log2(WIDTH)-1:0]; upper bits ignored.
- ovf_o: ADD when sign(A)==sign(B)!=sign(R); SUB when sign(A)!=sign(B) and sign(R)!=sign(A). Wraparound result always delivered.
- Accept = in_valid_i && in_ready_o at a rising edge; operands and code captured then and not sampled again.
- FSM states IDLE, MUL, DONE:
  - IDLE: in_ready_o=1. Accepting single-cycle op -> DONE with result registered. Accepting MUL -> MUL, counter=0, accumulator=0.
  - MUL: in_ready_o=0. Each cycle adds (A << shift) × next MUL_BPC bits of B to accumulator; after WIDTH/MUL_BPC iterations -> DONE.
  - DONE: out_valid_o=1; outputs held stable while out_ready_i=0. in_ready_o = out_ready_i. With out_ready_i=1 and no accept -> IDLE. With a simultaneous accept, the consumed result is replaced: single-cycle op -> stay DONE with new result; MUL -> MUL.
- zero_o/ovf_o/illegal_o are registered with result_o and change only with it.

## Timing
- Reset: state IDLE, out_valid_o=0, result_o=0, zero_o=0, ovf_o=0, illegal_o=0, counter=0, accumulator=0; in_ready_o=1 in the first cycle after reset.
- rst_i overrides everything, including an accept in the same cycle; an in-flight MUL is aborted with no output.
- Single-cycle op accepted at edge E: out_valid_o=1 from edge E (visible the following cycle); latency 1.
- MUL accepted at edge E: iterations on edges E+1..E+N, N=WIDTH/MUL_BPC; out_valid_o=1 from edge E+N. With WIDTH=32 and MUL_BPC=1, latency is 32.
- Sustained throughput: 1 single-cycle op per clock when out_ready_i=1. MUL throughput is 1 per N+1 clocks.
- in_ready_o is combinational from state and out_ready_i only, never from in_valid_i.
- out_valid_o never drops without a handshake (out_ready_i=1) or a reset.

## Test plan
- Reset, then ADD 0x7FFFFFFF + 1, out_ready_i=1: result 0x80000000, ovf_o=1, zero_o=0, out_valid_o one cycle after accept.
- SUB 5-5, then SLT 0xFFFFFFFF vs 1, then SLTU with the same operands, back to back: results 0 (zero_o=1), 1, 0; in_ready_o stays 1 throughout.
- MUL 0x0000FFFF × 0x00010001, WIDTH=32, MUL_BPC=1: in_ready_o=0 for 32 cycles, result 0xFFFFFFFF. Repeat with MUL_BPC=4: same result, 8 cycles.
- SRA 0x80000000 by 0x21 (amount 1): 0xC0000000. Then illegal code 1111: result 0, illegal_o=1.
- Hold out_ready_i=0 for 5 cycles after an AND result: result_o and flags stable, in_ready_o=0, new in_valid_i ignored. Raising out_ready_i with an OR pending accepts the OR on the same edge.
- Assert rst_i 10 cycles into a MUL: out_valid_o stays 0, state IDLE next cycle. A following ADD 2+3 returns 5.

Source files
------------

// File: rtl/alu_pipe.sv
// Handshaked EX-stage ALU: single-cycle logic/arith/shift/compare ops plus an
// iterative shift-and-add multiplier retiring MUL_BPC multiplier bits per cycle.
module alu_pipe #(
    parameter int WIDTH   = 32,
    parameter int MUL_BPC = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic [3:0]       ctrl_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             ovf_o,
    output logic             illegal_o
);

    localparam int SHW   = $clog2(WIDTH);
    localparam int N_ITR = WIDTH / MUL_BPC;
    localparam int CW    = (N_ITR > 1) ? $clog2(N_ITR) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(N_ITR - 1);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_MUL  = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;
    localparam logic [3:0] OP_SLTU = 4'b1010;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              valid_q, valid_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              zero_q, zero_d;
    logic              ovf_q, ovf_d;
    logic              illegal_q, illegal_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic              accept_s;
    logic [SHW-1:0]    shamt_s;
    logic [WIDTH-1:0]  sum_s, diff_s, alu_res_s, pp_s, mul_res_s;
    logic              alu_ovf_s, alu_ill_s;

    assign in_ready_o  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready_i);
    assign accept_s    = in_valid_i && in_ready_o;
    assign out_valid_o = valid_q;
    assign result_o    = result_q;
    assign zero_o      = zero_q;
    assign ovf_o       = ovf_q;
    assign illegal_o   = illegal_q;

    // Single-cycle datapath on the presented operands
    always_comb begin
        shamt_s   = src2_i[SHW-1:0];
        sum_s     = src1_i + src2_i;
        diff_s    = src1_i - src2_i;
        alu_res_s = {WIDTH{1'b0}};
        alu_ovf_s = 1'b0;
        alu_ill_s = 1'b0;
        case (ctrl_i)
            OP_AND:  alu_res_s = src1_i & src2_i;
            OP_OR:   alu_res_s = src1_i | src2_i;
            OP_XOR:  alu_res_s = src1_i ^ src2_i;
            OP_ADD: begin
                alu_res_s = sum_s;
                alu_ovf_s = (src1_i[WIDTH-1] == src2_i[WIDTH-1]) &&
                            (sum_s[WIDTH-1] != src1_i[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res_s = diff_s;
                alu_ovf_s = (src1_i[WIDTH-1] != src2_i[WIDTH-1]) &&
                            (diff_s[WIDTH-1] != src1_i[WIDTH-1]);
            end
            OP_SLL:  alu_res_s = src1_i << shamt_s;
            OP_SRL:  alu_res_s = src1_i >> shamt_s;
            OP_SRA:  alu_res_s = $unsigned($signed(src1_i) >>> shamt_s);
            OP_SLT:  alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
            OP_SLTU: alu_res_s = {{(WIDTH-1){1'b0}}, (src1_i < src2_i)};
            OP_MUL:  alu_res_s = {WIDTH{1'b0}};
            default: alu_ill_s = 1'b1;
        endcase
    end

    // Partial product for the next MUL_BPC multiplier bits
    always_comb begin
        pp_s = {WIDTH{1'b0}};
        for (int i = 0; i < MUL_BPC; i++) begin
            if (b_q[i]) begin
                pp_s = pp_s + (a_q << i);
            end else begin
                pp_s = pp_s;
            end
        end
        mul_res_s = acc_q + pp_s;
    end

    // Next-state and result-register logic
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        zero_d    = zero_q;
        ovf_d     = ovf_q;
        illegal_d = illegal_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept_s) begin
                    if (ctrl_i == OP_MUL) begin
                        state_d = S_MUL;
                        a_d     = src1_i;
                        b_d     = src2_i;
                        acc_d   = {WIDTH{1'b0}};
                        cnt_d   = {CW{1'b0}};
                    end else begin
                        state_d   = S_DONE;
                        result_d  = alu_res_s;
                        zero_d    = (alu_res_s == {WIDTH{1'b0}});
                        ovf_d     = alu_ovf_s;
                        illegal_d = alu_ill_s;
                    end
                end else if (out_ready_i) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            S_MUL: begin
                acc_d = mul_res_s;
                a_d   = a_q << MUL_BPC;
                b_d   = b_q >> MUL_BPC;
                if (cnt_q == LAST_CNT) begin
                    state_d   = S_DONE;
                    cnt_d     = {CW{1'b0}};
                    result_d  = mul_res_s;
                    zero_d    = (mul_res_s == {WIDTH{1'b0}});
                    ovf_d     = 1'b0;
                    illegal_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            default: state_d = S_IDLE;
        endcase
        valid_d = (state_d == S_DONE);
    end

    // State and result registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            valid_q   <= 1'b0;
            result_q  <= {WIDTH{1'b0}};
            zero_q    <= 1'b0;
            ovf_q     <= 1'b0;
            illegal_q <= 1'b0;
            a_q       <= {WIDTH{1'b0}};
            b_q       <= {WIDTH{1'b0}};
            acc_q     <= {WIDTH{1'b0}};
            cnt_q     <= {CW{1'b0}};
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            ovf_q     <= ovf_d;
            illegal_q <= illegal_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule
